// File: rtl/mem_access.sv
// MEM stage: load/store alignment, AdEL/AdES detection, data-side SRAM-like bus master, load extract/extend, writeback select.
// Latency: an access with addr_ok in the request cycle and data_ok one cycle later stalls the pipeline for exactly 1 cycle.
// Backpressure: mem_stall_request_o holds the pipeline until data_ok; a late stall_i parks read data in HOLD; a flush mid-access drains it in CANCEL.
//
// Ports:
//   clock_i, reset_i (async, active-low)                       clock / reset
//   valid_i, stall_i, flush_i                                  pipeline control
//   pc_i, aluop_i, alu_data_i, ram_write_data_i,
//   ram_write_enable_i, mem_to_reg_i, regfile_write_*_i,
//   exception_type_i, now_in_delayslot_i                       EX/MEM register contents
//   data_req_o, data_wr_o, data_size_o, data_addr_o,
//   data_wdata_o, data_addr_ok_i, data_data_ok_i, data_rdata_i data-side bus
//   pc_o, now_in_delayslot_o, regfile_write_*_o,
//   exception_type_o, bad_vaddr_o                              MEM/WB results
//   mem_stall_request_o                                        pipeline hold request
module mem_access #(
    parameter int EXC_ADEL_BIT = 27,
    parameter int EXC_ADES_BIT = 26
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] ram_write_data_i,
    input  logic        ram_write_enable_i,
    input  logic        mem_to_reg_i,
    input  logic        regfile_write_enable_i,
    input  logic [4:0]  regfile_write_addr_i,
    input  logic [31:0] exception_type_i,
    input  logic        now_in_delayslot_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic [31:0] pc_o,
    output logic        now_in_delayslot_o,
    output logic [4:0]  regfile_write_addr_o,
    output logic        regfile_write_enable_o,
    output logic [31:0] regfile_write_data_o,
    output logic [31:0] exception_type_o,
    output logic [31:0] bad_vaddr_o,
    output logic        mem_stall_request_o
);

    localparam logic [7:0] ALUOP_LB  = 8'h20;
    localparam logic [7:0] ALUOP_LH  = 8'h21;
    localparam logic [7:0] ALUOP_LW  = 8'h23;
    localparam logic [7:0] ALUOP_LBU = 8'h24;
    localparam logic [7:0] ALUOP_LHU = 8'h25;
    localparam logic [7:0] ALUOP_SB  = 8'h28;
    localparam logic [7:0] ALUOP_SH  = 8'h29;
    localparam logic [7:0] ALUOP_SW  = 8'h2b;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] rdata_buf;
    logic        buf_we;

    logic        is_byte, is_half, is_word, sign_ext;
    logic        misaligned, adel, ades, need_access;
    logic        req, stall;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] load_word, load_val, exc_add;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Access width / signedness decode
    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        sign_ext = 1'b0;
        case (aluop_i)
            ALUOP_LB:  begin is_byte = 1'b1; sign_ext = 1'b1; end
            ALUOP_LBU: is_byte = 1'b1;
            ALUOP_LH:  begin is_half = 1'b1; sign_ext = 1'b1; end
            ALUOP_LHU: is_half = 1'b1;
            ALUOP_LW:  is_word = 1'b1;
            ALUOP_SB:  is_byte = 1'b1;
            ALUOP_SH:  is_half = 1'b1;
            ALUOP_SW:  is_word = 1'b1;
            default:   ;
        endcase
    end

    assign misaligned  = (is_half & alu_data_i[0]) | (is_word & (alu_data_i[1:0] != 2'b00));
    assign adel        = mem_to_reg_i & misaligned;
    assign ades        = ram_write_enable_i & misaligned;
    assign need_access = valid_i & (mem_to_reg_i | ram_write_enable_i) & ~adel & ~ades
                         & (exception_type_i == 32'h0) & ~flush_i;

    always_comb begin
        exc_add               = '0;
        exc_add[EXC_ADEL_BIT] = adel;
        exc_add[EXC_ADES_BIT] = ades;
    end

    assign size  = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
    assign wdata = is_byte ? {4{ram_write_data_i[7:0]}} :
                   is_half ? {2{ram_write_data_i[15:0]}} : ram_write_data_i;

    // Read data is live only on the accepting data_ok cycle; afterwards it comes from the buffer.
    assign load_word = (state == S_DATA && data_data_ok_i) ? data_rdata_i : rdata_buf;

    always_comb begin
        case (alu_data_i[1:0])
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
    end

    assign load_half = alu_data_i[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        if (is_byte)
            load_val = {{24{sign_ext & load_byte[7]}}, load_byte};
        else if (is_half)
            load_val = {{16{sign_ext & load_half[15]}}, load_half};
        else
            load_val = load_word;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else begin
            state <= state_nxt;
            if (buf_we)
                rdata_buf <= data_rdata_i;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        buf_we    = 1'b0;
        case (state)
            S_IDLE: begin
                req = need_access;
                if (need_access)
                    state_nxt = data_addr_ok_i ? S_DATA : S_ADDR;
            end
            S_ADDR: begin
                req = 1'b1;
                // An accepted request must still be drained even if flushed in the same cycle.
                if (data_addr_ok_i)
                    state_nxt = flush_i ? S_CANCEL : S_DATA;
                else if (flush_i)
                    state_nxt = S_IDLE;
            end
            S_DATA: begin
                if (data_data_ok_i) begin
                    buf_we    = ~flush_i;
                    state_nxt = (stall_i && !flush_i) ? S_HOLD : S_IDLE;
                end else if (flush_i) begin
                    state_nxt = S_CANCEL;
                end
            end
            S_HOLD: begin
                if (!stall_i)
                    state_nxt = S_IDLE;
            end
            S_CANCEL: begin
                if (data_data_ok_i)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // HOLD has its data already; CANCEL stalls regardless of what sits in MEM.
    assign stall = (state == S_CANCEL) |
                   (need_access & ~(state == S_DATA & data_data_ok_i) & (state != S_HOLD));

    // All outputs forced low while reset is asserted.
    assign data_req_o             = reset_i & req;
    assign data_wr_o              = reset_i & ram_write_enable_i;
    assign data_size_o            = reset_i ? size : 2'd0;
    assign data_addr_o            = reset_i ? alu_data_i : 32'h0;
    assign data_wdata_o           = reset_i ? wdata : 32'h0;
    assign pc_o                   = reset_i ? pc_i : 32'h0;
    assign now_in_delayslot_o     = reset_i & now_in_delayslot_i;
    assign regfile_write_addr_o   = reset_i ? regfile_write_addr_i : 5'd0;
    assign regfile_write_enable_o = reset_i & regfile_write_enable_i & ~adel;
    assign regfile_write_data_o   = reset_i ? (mem_to_reg_i ? load_val : alu_data_i) : 32'h0;
    assign exception_type_o       = reset_i ? (exception_type_i | exc_add) : 32'h0;
    assign bad_vaddr_o            = (reset_i & (adel | ades)) ? alu_data_i : 32'h0;
    assign mem_stall_request_o    = reset_i & stall;

endmodule
